// File: rtl/axi_lite_regif.sv
// rtl/axi_lite_regif.sv - AXI4-Lite slave to single-cycle req/ack register protocol bridge
module axi_lite_regif #(
  parameter int ADDRESS_WIDTH = 11,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  // write address channel
  input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  // write data channel
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  // write response channel
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  // read address channel
  input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  // read data channel
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  // regmap side
  output logic                     wreq_o,
  output logic [ADDRESS_WIDTH-3:0] waddr_o,
  output logic [31:0]              wdata_o,
  input  logic                     wack,
  output logic                     rreq_o,
  output logic [ADDRESS_WIDTH-3:0] raddr_o,
  input  logic [31:0]              rdata,
  input  logic                     rack
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic        TO_ENABLE   = (ACK_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST     = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

  w_state_t    r_w_state;
  w_state_t    w_w_state_nxt;
  r_state_t    r_r_state;
  r_state_t    w_r_state_nxt;

  logic        r_init;
  logic        r_aw_held;
  logic        r_w_held;
  logic [15:0] r_w_cnt;
  logic [15:0] r_r_cnt;
  logic [1:0]  r_bresp;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [ADDRESS_WIDTH-3:0] r_waddr;
  logic [31:0]              r_wdata;
  logic [ADDRESS_WIDTH-3:0] r_raddr;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_both_held;
  logic        w_w_timeout;
  logic        w_r_timeout;

  // Byte-lane strobes and the byte offset bits carry no information for full-word registers.
  logic        w_unused;
  assign w_unused = &{1'b0, s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readys stay low through reset and rise on the first clock after release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_init <= 1'b0;
    else           r_init <= 1'b1;
  end

  assign s_axi_awready = r_init && (r_w_state == W_IDLE) && !r_aw_held;
  assign s_axi_wready  = r_init && (r_w_state == W_IDLE) && !r_w_held;
  assign s_axi_arready = r_init && (r_r_state == R_IDLE);

  assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_w_hs      = s_axi_wvalid  && s_axi_wready;
  assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
  assign w_both_held = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // An ack in the same cycle takes priority, so timeout is only a fallback.
  assign w_w_timeout = TO_ENABLE && (r_w_cnt == TO_LAST);
  assign w_r_timeout = TO_ENABLE && (r_r_cnt == TO_LAST);

  assign wreq_o       = (r_w_state == W_REQ);
  assign rreq_o       = (r_r_state == R_REQ);
  assign s_axi_bvalid = (r_w_state == W_RESP);
  assign s_axi_rvalid = (r_r_state == R_RESP);
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rdata  = r_rdata;
  assign waddr_o      = r_waddr;
  assign wdata_o      = r_wdata;
  assign raddr_o      = r_raddr;

  // ---------------------------------------------------------------- write path

  // Write FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_w_state <= W_IDLE;
    else           r_w_state <= w_w_state_nxt;
  end

  // Write FSM next-state: AW and W may arrive in either order before the request.
  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_both_held) w_w_state_nxt = W_REQ;
      W_REQ:   w_w_state_nxt = W_WAIT;
      W_WAIT:  if (wack || w_w_timeout) w_w_state_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  // Beat capture; address and data hold until the next captured write because
  // the regmap decodes them combinationally.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      if (w_aw_hs) r_waddr <= s_axi_awaddr[ADDRESS_WIDTH-1:2];
      if (w_w_hs)  r_wdata <= s_axi_wdata;
      if (r_w_state == W_IDLE && w_both_held) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
      end
    end
  end

  // Write wait counter and response code.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_w_cnt <= '0;
      r_bresp <= RESP_OKAY;
    end else begin
      if (r_w_state == W_REQ) begin
        r_w_cnt <= '0;
      end else if (r_w_state == W_WAIT) begin
        r_w_cnt <= r_w_cnt + 16'd1;
        if (wack)             r_bresp <= RESP_OKAY;
        else if (w_w_timeout) r_bresp <= RESP_SLVERR;
      end
    end
  end

  // ---------------------------------------------------------------- read path

  // Read FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_r_state <= R_IDLE;
    else           r_r_state <= w_r_state_nxt;
  end

  // Read FSM next-state.
  always_comb begin
    w_r_state_nxt = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_REQ;
      R_REQ:   w_r_state_nxt = R_WAIT;
      R_WAIT:  if (rack || w_r_timeout) w_r_state_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read address capture.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    r_raddr <= '0;
    else if (w_ar_hs) r_raddr <= s_axi_araddr[ADDRESS_WIDTH-1:2];
  end

  // Read wait counter, response data and code; a timeout returns zero data.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_r_cnt <= '0;
      r_rresp <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      if (r_r_state == R_REQ) begin
        r_r_cnt <= '0;
      end else if (r_r_state == R_WAIT) begin
        r_r_cnt <= r_r_cnt + 16'd1;
        if (rack) begin
          r_rdata <= rdata;
          r_rresp <= RESP_OKAY;
        end else if (w_r_timeout) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regif.sv
// tb/tb_axi_lite_regif.sv - directed self-checking bench for axi_lite_regif
module tb_axi_lite_regif;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [10:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [10:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        wreq_o;
  logic [8:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        wack;
  logic        rreq_o;
  logic [8:0]  raddr_o;
  logic [31:0] rdata;
  logic        rack;

  int errors = 0;
  int checks = 0;

  // regmap model: acks one cycle after each request when enabled
  logic        ack_en = 1'b1;
  logic [31:0] rd_value = 32'h0;
  logic        prev_wreq = 1'b0;
  logic        prev_rreq = 1'b0;

  axi_lite_regif #(.ADDRESS_WIDTH(11), .ACK_TIMEOUT(16)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .wreq_o(wreq_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .wack(wack),
    .rreq_o(rreq_o), .raddr_o(raddr_o), .rdata(rdata), .rack(rack)
  );

  always #5 clk_i = ~clk_i;

  always begin
    @(posedge clk_i);
    #2;
    wack  = ack_en && prev_wreq;
    rack  = ack_en && prev_rreq;
    rdata = (ack_en && prev_rreq) ? rd_value : 32'hDEAD_BEEF;
    prev_wreq = wreq_o;
    prev_rreq = rreq_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    tick();
    tick();
    checks++; if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0) begin
      errors++; $display("FAIL reset_readys got=%b%b%b exp=000", s_axi_awready, s_axi_wready, s_axi_arready); end
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || wreq_o !== 1'b0 || rreq_o !== 1'b0) begin
      errors++; $display("FAIL reset_valids got=%b%b%b%b exp=0000", s_axi_bvalid, s_axi_rvalid, wreq_o, rreq_o); end
    checks++; if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h exp 0", s_axi_bresp, s_axi_rresp, s_axi_rdata); end
    checks++; if (waddr_o !== 9'h0 || raddr_o !== 9'h0 || wdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr got waddr=%h raddr=%h wdata=%h exp 0", waddr_o, raddr_o, wdata_o); end
    reset_ni = 1'b1;
    #1;
    checks++; if (s_axi_awready !== 1'b0) begin
      errors++; $display("FAIL reset_release_awready got=%b exp=0", s_axi_awready); end
    tick();
    checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL post_reset_readys got=%b%b%b exp=111", s_axi_awready, s_axi_wready, s_axi_arready); end
  endtask

  task automatic test_write_same_cycle();
    s_axi_awaddr = 11'h018; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h3; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b1;
    checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
      errors++; $display("FAIL wr_ready got=%b%b exp=11", s_axi_awready, s_axi_wready); end
    tick(); // T+1
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if (wreq_o !== 1'b1 || waddr_o !== 9'h006 || wdata_o !== 32'h3) begin
      errors++; $display("FAIL wr_req got wreq=%b waddr=%h wdata=%h exp 1 006 3", wreq_o, waddr_o, wdata_o); end
    checks++; if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
      errors++; $display("FAIL wr_busy_ready got=%b%b exp=00", s_axi_awready, s_axi_wready); end
    tick(); // T+2
    checks++; if (wreq_o !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      errors++; $display("FAIL wr_t2 got wreq=%b bvalid=%b exp 0 0", wreq_o, s_axi_bvalid); end
    tick(); // T+3
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL wr_bresp got bvalid=%b bresp=%b exp 1 00", s_axi_bvalid, s_axi_bresp); end
    s_axi_bready = 1'b1;
    tick(); // T+4
    s_axi_bready = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || wdata_o !== 32'h3) begin
      errors++; $display("FAIL wr_done got bvalid=%b awready=%b wdata=%h exp 0 1 3", s_axi_bvalid, s_axi_awready, wdata_o); end
  endtask

  task automatic test_w_before_aw();
    int nreq;
    int nb;
    nreq = 0; nb = 0;
    s_axi_wdata = 32'hA5A5_0F0F; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    checks++; if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b1 || wreq_o !== 1'b0) begin
      errors++; $display("FAIL wfirst_held got wready=%b awready=%b wreq=%b exp 0 1 0", s_axi_wready, s_axi_awready, wreq_o); end
    tick();
    tick();
    checks++; if (wreq_o !== 1'b0) begin
      errors++; $display("FAIL wfirst_early_req got=%b exp=0", wreq_o); end
    s_axi_awaddr = 11'h040; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    checks++; if (wreq_o !== 1'b1 || waddr_o !== 9'h010 || wdata_o !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL wfirst_req got wreq=%b waddr=%h wdata=%h exp 1 010 a5a50f0f", wreq_o, waddr_o, wdata_o); end
    s_axi_bready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wreq_o) nreq++;
      if (s_axi_bvalid && s_axi_bready) nb++;
    end
    s_axi_bready = 1'b0;
    checks++; if (nreq != 0 || nb != 1) begin
      errors++; $display("FAIL wfirst_counts got extra_req=%0d bresp=%0d exp 0 1", nreq, nb); end
  endtask

  task automatic test_read();
    rd_value = 32'h4653_7E7E;
    s_axi_araddr = 11'h00C; s_axi_arvalid = 1'b1;
    checks++; if (s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL rd_arready got=%b exp=1", s_axi_arready); end
    tick(); // T+1
    s_axi_arvalid = 1'b0;
    checks++; if (rreq_o !== 1'b1 || raddr_o !== 9'h003) begin
      errors++; $display("FAIL rd_req got rreq=%b raddr=%h exp 1 003", rreq_o, raddr_o); end
    tick(); // T+2
    checks++; if (s_axi_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_early_rvalid got=%b exp=0", s_axi_rvalid); end
    tick(); // T+3
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h4653_7E7E || s_axi_rresp !== 2'b00) begin
      errors++; $display("FAIL rd_resp got rvalid=%b rdata=%h rresp=%b exp 1 46537e7e 00", s_axi_rvalid, s_axi_rdata, s_axi_rresp); end
    rd_value = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h4653_7E7E || s_axi_arready !== 1'b0) begin
        errors++; $display("FAIL rd_stall%0d got rvalid=%b rdata=%h arready=%b exp 1 46537e7e 0", i, s_axi_rvalid, s_axi_rdata, s_axi_arready); end
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL rd_done got rvalid=%b arready=%b exp 0 1", s_axi_rvalid, s_axi_arready); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    s_axi_awaddr = 11'h100; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h5555_AAAA; s_axi_wvalid = 1'b1;
    s_axi_araddr = 11'h104; s_axi_arvalid = 1'b1;
    tick(); // T+1
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    for (int i = 0; i < 16; i++) tick(); // T+17
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
      errors++; $display("FAIL to_early got bvalid=%b rvalid=%b exp 0 0", s_axi_bvalid, s_axi_rvalid); end
    tick(); // T+18
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10) begin
      errors++; $display("FAIL to_bresp got bvalid=%b bresp=%b exp 1 10", s_axi_bvalid, s_axi_bresp); end
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b10 || s_axi_rdata !== 32'h0) begin
      errors++; $display("FAIL to_rresp got rvalid=%b rresp=%b rdata=%h exp 1 10 0", s_axi_rvalid, s_axi_rresp, s_axi_rdata); end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    ack_en = 1'b1;
    s_axi_awaddr = 11'h008; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0077; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if (wreq_o !== 1'b1 || waddr_o !== 9'h002) begin
      errors++; $display("FAIL to_next_req got wreq=%b waddr=%h exp 1 002", wreq_o, waddr_o); end
    tick();
    tick();
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL to_next_bresp got bvalid=%b bresp=%b exp 1 00", s_axi_bvalid, s_axi_bresp); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic test_concurrent();
    rd_value = 32'hCAFE_0001;
    s_axi_araddr = 11'h004; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 11'h044; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1234_5678; s_axi_wvalid = 1'b1;
    tick(); // T+1
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if (wreq_o !== 1'b1 || rreq_o !== 1'b1 || waddr_o !== 9'h011 || raddr_o !== 9'h001) begin
      errors++; $display("FAIL cc_req got wreq=%b rreq=%b waddr=%h raddr=%h exp 1 1 011 001", wreq_o, rreq_o, waddr_o, raddr_o); end
    tick();
    tick(); // T+3
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hCAFE_0001) begin
      errors++; $display("FAIL cc_resp got bvalid=%b rvalid=%b rdata=%h exp 1 1 cafe0001", s_axi_bvalid, s_axi_rvalid, s_axi_rdata); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b1) begin
      errors++; $display("FAIL cc_indep got bvalid=%b rvalid=%b exp 0 1", s_axi_bvalid, s_axi_rvalid); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL cc_rdone got rvalid=%b arready=%b exp 0 1", s_axi_rvalid, s_axi_arready); end
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    s_axi_araddr = 11'h010; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    tick(); // in R_WAIT
    reset_ni = 1'b0;
    #1;
    checks++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || rreq_o !== 1'b0 || raddr_o !== 9'h0) begin
      errors++; $display("FAIL rst_mid_rd got rvalid=%b arready=%b rreq=%b raddr=%h exp 0 0 0 0", s_axi_rvalid, s_axi_arready, rreq_o, raddr_o); end
    checks++; if (s_axi_rdata !== 32'h0 || waddr_o !== 9'h0 || wdata_o !== 32'h0 || s_axi_awready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wr got rdata=%h waddr=%h wdata=%h awready=%b exp 0", s_axi_rdata, waddr_o, wdata_o, s_axi_awready); end
    tick();
    tick();
    reset_ni = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      checks++; if (s_axi_rvalid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_stale_rvalid cycle=%0d got=%b exp=0", i, s_axi_rvalid); end
    end
    rd_value = 32'h0BAD_F00D;
    s_axi_araddr = 11'h008; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (rreq_o !== 1'b1 || raddr_o !== 9'h002) begin
      errors++; $display("FAIL rst_post_req got rreq=%b raddr=%h exp 1 002", rreq_o, raddr_o); end
    tick();
    tick();
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h0BAD_F00D || s_axi_rresp !== 2'b00) begin
      errors++; $display("FAIL rst_post_resp got rvalid=%b rdata=%h rresp=%b exp 1 0badf00d 00", s_axi_rvalid, s_axi_rdata, s_axi_rresp); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    wack = 1'b0; rack = 1'b0; rdata = '0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read();
    test_timeout();
    test_concurrent();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
